// File: rtl/text_console_pkg.sv
// text_console_pkg: geometry, control codes, FSM states and cell helpers shared by the text console writer.
package text_console_pkg;

    localparam int unsigned CharacterColumns = 60;
    localparam int unsigned CharacterLines   = 33;
    localparam int unsigned CellCount        = CharacterColumns * CharacterLines;
    localparam int unsigned AddressWidth     = $clog2(CellCount);
    localparam int unsigned ColumnWidth      = $clog2(CharacterColumns);
    localparam int unsigned LineWidth        = $clog2(CharacterLines);
    localparam int unsigned CellWidth        = 16;

    localparam logic [7:0] CODE_NUL   = 8'h00;
    localparam logic [7:0] CODE_BS    = 8'h08;
    localparam logic [7:0] CODE_LF    = 8'h0A;
    localparam logic [7:0] CODE_FF    = 8'h0C;
    localparam logic [7:0] CODE_CR    = 8'h0D;
    localparam logic [7:0] CODE_SPACE = 8'h20;

    localparam logic [7:0] CLEAR_ATTR_DEFAULT = 8'h07;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_CLEAR_LINE,
        ST_CLEAR_SCREEN
    } state_t;

    typedef struct packed {
        logic [3:0] bg;
        logic [3:0] fg;
        logic [7:0] code;
    } cell_t;

    // Row sum modulo CharacterLines by compare-and-subtract (both operands already in range).
    function automatic logic [LineWidth-1:0] line_add(input logic [LineWidth-1:0] a,
                                                      input logic [LineWidth-1:0] b);
        logic [LineWidth:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= (LineWidth+1)'(CharacterLines)) begin
            sum = sum - (LineWidth+1)'(CharacterLines);
        end
        return sum[LineWidth-1:0];
    endfunction

    // Address of column 0 of a physical row.
    function automatic logic [AddressWidth-1:0] row_base(input logic [LineWidth-1:0] row);
        return AddressWidth'(row) * AddressWidth'(CharacterColumns);
    endfunction

    // Space character carrying the given attribute byte.
    function automatic logic [CellWidth-1:0] blank_cell(input logic [7:0] attr);
        return {attr, CODE_SPACE};
    endfunction

endpackage

// File: rtl/text_console_writer.sv
// text_console_writer: accepts attributed characters, interprets control codes, tracks the cursor,
// scrolls through a circular TopLine offset and writes cells into the character buffer.
// Build macro TEXT_CONSOLE_CLEAR_ON_RESET_EN: clear the whole buffer with attribute 8'h07 after reset.
module text_console_writer
    import text_console_pkg::*;
(
    input  logic                    ScanClock,
    input  logic                    ResetN,
    input  logic                    CharValid,
    output logic                    CharReady,
    input  logic [CellWidth-1:0]    CharData,
    output logic                    BufWriteEnable,
    output logic [AddressWidth-1:0] BufWriteAddress,
    output logic [CellWidth-1:0]    BufWriteData,
    output logic [ColumnWidth-1:0]  CursorColumn,
    output logic [LineWidth-1:0]    CursorLine,
    output logic [LineWidth-1:0]    TopLine,
    output logic                    Busy
);

    state_t state, state_next;

    logic [AddressWidth-1:0] clr_addr, clr_addr_next;
    logic [AddressWidth-1:0] clr_left, clr_left_next;
    logic [7:0]              clr_attr, clr_attr_next;

    logic                    we_next;
    logic [AddressWidth-1:0] waddr_next;
    logic [CellWidth-1:0]    wdata_next;
    logic [ColumnWidth-1:0]  col_next;
    logic [LineWidth-1:0]    line_next;
    logic [LineWidth-1:0]    top_next;

    cell_t                   in_cell;
    logic [7:0]              in_attr;
    logic                    accept;
    logic                    is_print;
    logic                    is_ff;
    logic                    advance;
    logic                    at_bottom;
    logic                    scroll;
    logic [ColumnWidth-1:0]  col_after;
    logic [LineWidth-1:0]    phys_row;
    logic [AddressWidth-1:0] cur_addr;
    logic [AddressWidth-1:0] top_base;

    assign in_cell   = cell_t'(CharData);
    assign in_attr   = {in_cell.bg, in_cell.fg};
    assign accept    = CharValid && (state == ST_IDLE);
    assign at_bottom = (CursorLine == LineWidth'(CharacterLines - 1));
    assign scroll    = advance && at_bottom;
    assign phys_row  = line_add(TopLine, CursorLine);
    assign cur_addr  = row_base(phys_row) + AddressWidth'(CursorColumn);
    assign top_base  = row_base(TopLine);

    // Classify the incoming code and compute the column it leaves behind.
    always_comb begin
        is_print  = 1'b0;
        is_ff     = 1'b0;
        advance   = 1'b0;
        col_after = CursorColumn;
        case (in_cell.code)
            CODE_NUL: begin
            end
            CODE_BS: begin
                if (CursorColumn != '0) col_after = CursorColumn - ColumnWidth'(1);
            end
            CODE_CR: begin
                col_after = '0;
            end
            CODE_LF: begin
                col_after = '0;
                advance   = 1'b1;
            end
            CODE_FF: begin
                col_after = '0;
                is_ff     = 1'b1;
            end
            default: begin
                is_print = 1'b1;
                if (CursorColumn == ColumnWidth'(CharacterColumns - 1)) begin
                    col_after = '0;
                    advance   = 1'b1;
                end else begin
                    col_after = CursorColumn + ColumnWidth'(1);
                end
            end
        endcase
    end

    // State register.
    always_ff @(posedge ScanClock or negedge ResetN) begin
        if (!ResetN) state <= ST_INIT;
        else         state <= state_next;
    end

    // Next-state: clears run until their remaining-cell count is exhausted.
    always_comb begin
        state_next = state;
        case (state)
            ST_INIT: begin
`ifdef TEXT_CONSOLE_CLEAR_ON_RESET_EN
                state_next = ST_CLEAR_SCREEN;
`else
                state_next = ST_IDLE;
`endif
            end
            ST_IDLE: begin
                if (accept) begin
                    if (is_ff)       state_next = ST_CLEAR_SCREEN;
                    else if (scroll) state_next = ST_CLEAR_LINE;
                end
            end
            ST_CLEAR_LINE, ST_CLEAR_SCREEN: begin
                if (clr_left == '0) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output/datapath next values: character writes, cursor moves, and the clear engine.
    always_comb begin
        we_next       = 1'b0;
        waddr_next    = BufWriteAddress;
        wdata_next    = BufWriteData;
        col_next      = CursorColumn;
        line_next     = CursorLine;
        top_next      = TopLine;
        clr_addr_next = clr_addr;
        clr_left_next = clr_left;
        clr_attr_next = clr_attr;
        case (state)
            ST_INIT: begin
                clr_addr_next = '0;
                clr_left_next = AddressWidth'(CellCount);
                clr_attr_next = CLEAR_ATTR_DEFAULT;
            end
            ST_IDLE: begin
                if (accept) begin
                    if (is_ff) begin
                        // First clear cell goes out in the acceptance slot itself.
                        we_next       = 1'b1;
                        waddr_next    = '0;
                        wdata_next    = blank_cell(in_attr);
                        col_next      = '0;
                        line_next     = '0;
                        top_next      = '0;
                        clr_addr_next = AddressWidth'(1);
                        clr_left_next = AddressWidth'(CellCount - 1);
                        clr_attr_next = in_attr;
                    end else begin
                        col_next = col_after;
                        if (is_print) begin
                            we_next    = 1'b1;
                            waddr_next = cur_addr;
                            wdata_next = CharData;
                        end
                        if (advance && !at_bottom) line_next = CursorLine + LineWidth'(1);
                        if (scroll) begin
                            // The old top row becomes the new bottom row and is blanked.
                            top_next      = line_add(TopLine, LineWidth'(1));
                            clr_attr_next = in_attr;
                            if (is_print) begin
                                clr_addr_next = top_base;
                                clr_left_next = AddressWidth'(CharacterColumns);
                            end else begin
                                we_next       = 1'b1;
                                waddr_next    = top_base;
                                wdata_next    = blank_cell(in_attr);
                                clr_addr_next = top_base + AddressWidth'(1);
                                clr_left_next = AddressWidth'(CharacterColumns - 1);
                            end
                        end
                    end
                end
            end
            ST_CLEAR_LINE, ST_CLEAR_SCREEN: begin
                if (clr_left != '0) begin
                    we_next       = 1'b1;
                    waddr_next    = clr_addr;
                    wdata_next    = blank_cell(clr_attr);
                    clr_addr_next = clr_addr + AddressWidth'(1);
                    clr_left_next = clr_left - AddressWidth'(1);
                end
            end
            default: begin
            end
        endcase
    end

    // Registered outputs and clear-engine state.
    always_ff @(posedge ScanClock or negedge ResetN) begin
        if (!ResetN) begin
            CharReady       <= 1'b0;
            Busy            <= 1'b0;
            BufWriteEnable  <= 1'b0;
            BufWriteAddress <= '0;
            BufWriteData    <= '0;
            CursorColumn    <= '0;
            CursorLine      <= '0;
            TopLine         <= '0;
            clr_addr        <= '0;
            clr_left        <= '0;
            clr_attr        <= '0;
        end else begin
            CharReady       <= (state_next == ST_IDLE);
            Busy            <= (state_next == ST_CLEAR_LINE) || (state_next == ST_CLEAR_SCREEN);
            BufWriteEnable  <= we_next;
            BufWriteAddress <= waddr_next;
            BufWriteData    <= wdata_next;
            CursorColumn    <= col_next;
            CursorLine      <= line_next;
            TopLine         <= top_next;
            clr_addr        <= clr_addr_next;
            clr_left        <= clr_left_next;
            clr_attr        <= clr_attr_next;
        end
    end

endmodule

// File: doc/text_console_writer.md
# text_console_writer

Stream-to-character-buffer writer that sits directly upstream of the VGA text-mode controller. It accepts attributed character codes over a valid/ready stream and interprets a small set of control codes. It tracks a cursor and writes 16-bit cells ({BgC, FgC, Char}) into the controller's character buffer RAM through a single write port. Scrolling uses a circular row offset (TopLine), which the display side adds to its row index, so no buffer reads are ever needed.

## Interface
- CharacterColumns, 60: columns per screen; must match the text-mode controller.
- CharacterLines, 33: text rows per screen.
- AddressWidth, $clog2(CharacterColumns*CharacterLines): buffer address width.
- ColumnWidth / LineWidth, $clog2(CharacterColumns) / $clog2(CharacterLines): cursor widths.
- ScanClock  in  1  single clock for the block.
- ResetN  in  1  asynchronous, active-low reset.
- CharValid  in  1  stream valid.
- CharReady  out  1  stream ready.
- CharData  in  16  [15:12] background, [11:8] foreground, [7:0] character code.
- BufWriteEnable  out  1  one-cycle write strobe into the character buffer.
- BufWriteAddress  out  AddressWidth  physical cell index, physRow*CharacterColumns+col.
- BufWriteData  out  16  cell value.
- CursorColumn  out  ColumnWidth  logical cursor column.
- CursorLine  out  LineWidth  logical cursor row, 0 = top of screen.
- TopLine  out  LineWidth  physical row currently displayed at logical row 0.
- Busy  out  1  high while a clear engine runs.

## Operation
- Handshake: a transfer occurs on a rising edge with CharValid && CharReady. CharReady is high exactly when the state is IDLE. CharData must be held while CharValid is high and not accepted.
- Physical row = (TopLine + CursorLine) mod CharacterLines. All mod arithmetic uses compare-and-subtract; no dividers.
- States:
  - IDLE: accept characters.
  - CLEAR_LINE: write CharacterColumns blank cells on one physical row.
  - CLEAR_SCREEN: write all CharacterColumns*CharacterLines cells.
  - A clear writes one cell per cycle at ascending addresses, then returns to IDLE.
- Blank cell = {accepted attribute byte, 8'h20}.
- Code handling, applied on acceptance:
  - 0x00: consumed; no write, cursor unchanged.
  - 0x08 (BS): if CursorColumn > 0, decrement it; no write.
  - 0x0D (CR): CursorColumn = 0.
  - 0x0A (LF): CursorColumn = 0, then line-advance.
  - 0x0C (FF): cursor = (0,0), TopLine = 0, enter CLEAR_SCREEN.
  - Any other code, including 0x01–0x1F not listed above: write the cell at the cursor, then increment CursorColumn. At CharacterColumns-1 the increment instead sets CursorColumn = 0 and performs a line-advance.
- Line-advance:
  - If CursorLine < CharacterLines-1: CursorLine + 1.
  - Otherwise: TopLine = (TopLine+1) mod CharacterLines, CursorLine unchanged, and enter CLEAR_LINE on the new bottom physical row (the previous TopLine row). The clear uses the attribute of the character that triggered it.
- A single accepted printable character at the bottom-right cell produces both its own write and the scroll/clear.

## Timing
- Reset values: CharReady 0, BufWriteEnable 0, BufWriteAddress 0, BufWriteData 0, CursorColumn 0, CursorLine 0, TopLine 0, Busy 0 (state per Configuration).
- Printable character: BufWriteEnable is high for exactly one cycle, the cycle after acceptance. Address and data are registered alongside the strobe.
- Without a scroll, CharReady stays high, giving one character per cycle.
- Scroll: CharReady drops the cycle after acceptance. The character's own write is issued first, then CharacterColumns clear writes in consecutive cycles. CharReady returns high the cycle after the last clear write, so the bubble is CharacterColumns+1 cycles.
- FF: CharacterColumns*CharacterLines consecutive writes starting the cycle after acceptance.
- Busy equals !CharReady.
- TopLine and the cursor update in the cycle after acceptance.
- ResetN asserted mid-clear aborts immediately. No further writes occur; the partially cleared screen remains.

## Configuration
- TEXT_CONSOLE_CLEAR_ON_RESET_EN:
  - Defined: on reset release, the FSM enters CLEAR_SCREEN with attribute 8'h07. CharReady is low until all cells are written.
  - Undefined: the FSM leaves reset in IDLE with CharReady high one cycle after ResetN deasserts, and buffer contents are untouched.

## Structure
- Shared package text_console_pkg: control-code localparams (CODE_NUL, CODE_BS, CODE_LF, CODE_FF, CODE_CR, CODE_SPACE), the state enum, and the default clear attribute 8'h07.
- No sub-module: the clear engine is a counter inside the FSM.

## Test plan
- Reset with macro undefined, send 0x1F41 ('A', fg F, bg 1) → one write, addr 0, data 16'h1F41; CursorColumn = 1.
- Send 60 printable characters back-to-back → 60 consecutive strobes at addresses 0..59, CharReady never drops; cursor = (0,1).
- Fill to row 32, then send LF with attr 0x20 → TopLine = 1, CursorLine = 32, 60 writes of 16'h2020 at addresses 0..59, CharReady low for 60 cycles.
- Send BS at column 0 → no change. Send 'B', CR, 'C' → 'C' overwrites the 'B' address.
- Send FF → 1980 writes at addresses 0..1979, TopLine = 0, cursor (0,0). Assert ResetN low at write 500 → no writes after reset; outputs return to reset values.
- Macro defined: after reset, 1980 writes of 16'h0720 with CharReady low throughout, then CharReady high.
